// File: rtl/alt_dfe_dprio_pkg.sv
// rtl/alt_dfe_dprio_pkg.sv - shared FSM state type and default constants for the DPRIO responder
package alt_dfe_dprio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WBUSY = 2'd1,
    RBUSY = 2'd2
  } dprio_state_e;

  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_REG_INDEX_WIDTH = 4;
  localparam int DEF_BUSY_CYCLES     = 4;

  // Value returned for a read whose address falls outside the register file
  localparam logic [DEF_DATA_WIDTH-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/alt_dfe_dprio_regfile.sv
// rtl/alt_dfe_dprio_regfile.sv - register file, synchronous write, combinational read, async clear
module alt_dfe_dprio_regfile #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic [INDEX_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]  rdata_o
);

  localparam int NUM_REGS = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  // Entries clear on reset; a write lands on the clock edge that ends the access
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alt_dfe_dprio_resp.sv
// rtl/alt_dfe_dprio_resp.sv - DPRIO responder with busy timing; ALT_DFE_DPRIO_RESP_ADDRCHK_EN adds address range checking
module alt_dfe_dprio_resp
  import alt_dfe_dprio_pkg::*;
#(
  parameter int DPRIO_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DPRIO_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_INDEX_WIDTH  = DEF_REG_INDEX_WIDTH,
  parameter int BUSY_CYCLES      = DEF_BUSY_CYCLES
) (
  input  logic                        i_avmm_clk,
  input  logic                        i_resetn,
  input  logic                        i_dprio_wren,
  input  logic                        i_dprio_rden,
  input  logic [DPRIO_ADDR_WIDTH-1:0] i_dprio_addr,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_dprio_data,
  output logic                        o_dprio_busy,
  output logic [DPRIO_DATA_WIDTH-1:0] o_dprio_in,
  output logic                        o_proto_err
);

  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

  dprio_state_e                state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [DPRIO_ADDR_WIDTH-1:0] addr_q;
  logic [DPRIO_DATA_WIDTH-1:0] wdata_q;
  logic [DPRIO_DATA_WIDTH-1:0] rdata_q;
  logic                        busy_q;
  logic                        err_q;
  logic                        wren_prev_q;
  logic                        rden_prev_q;
  logic                        hist_vld_q;

  logic                        wr_edge;
  logic                        rd_edge;
  logic                        last_cyc;
  logic                        acc_oor;
  logic                        cur_oor;
  logic                        rf_we;
  logic [DPRIO_DATA_WIDTH-1:0] rf_rdata;
  logic [DPRIO_DATA_WIDTH-1:0] rd_value;

  // hist_vld_q masks the first cycle after reset so a strobe already high is not an edge
  assign wr_edge  = hist_vld_q & i_dprio_wren & ~wren_prev_q;
  assign rd_edge  = hist_vld_q & i_dprio_rden & ~rden_prev_q;
  assign last_cyc = (state_q != IDLE) && (cnt_q == CNT_W'(1));

`ifdef ALT_DFE_DPRIO_RESP_ADDRCHK_EN
  localparam logic [DPRIO_DATA_WIDTH-1:0] ERR_FILL = {DPRIO_DATA_WIDTH{ERR_RDATA[0]}};
  assign acc_oor  = (i_dprio_addr >> REG_INDEX_WIDTH) != '0;
  assign cur_oor  = (addr_q >> REG_INDEX_WIDTH) != '0;
  assign rd_value = cur_oor ? ERR_FILL : rf_rdata;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[DPRIO_ADDR_WIDTH-1:REG_INDEX_WIDTH];
  assign acc_oor  = 1'b0;
  assign cur_oor  = 1'b0;
  assign rd_value = rf_rdata;
`endif

  assign rf_we = (state_q == WBUSY) && last_cyc && !cur_oor;

  alt_dfe_dprio_regfile #(
    .DATA_WIDTH  (DPRIO_DATA_WIDTH),
    .INDEX_WIDTH (REG_INDEX_WIDTH)
  ) u_regfile (
    .clk_i   (i_avmm_clk),
    .rst_n_i (i_resetn),
    .we_i    (rf_we),
    .waddr_i (addr_q[REG_INDEX_WIDTH-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[REG_INDEX_WIDTH-1:0]),
    .rdata_o (rf_rdata)
  );

  // Access FSM: accept one edge in IDLE, count down busy, complete on the last busy cycle
  always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      wren_prev_q <= 1'b0;
      rden_prev_q <= 1'b0;
      hist_vld_q  <= 1'b0;
    end else begin
      hist_vld_q  <= 1'b1;
      wren_prev_q <= i_dprio_wren;
      rden_prev_q <= i_dprio_rden;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_edge && rd_edge) begin
            err_q <= 1'b1;
          end else if (wr_edge || rd_edge) begin
            state_q <= wr_edge ? WBUSY : RBUSY;
            cnt_q   <= CNT_W'(BUSY_CYCLES);
            busy_q  <= 1'b1;
            addr_q  <= i_dprio_addr;
            wdata_q <= i_dprio_data;
            // With a single busy cycle the range error lands on the acceptance edge
            if (BUSY_CYCLES == 1 && acc_oor) err_q <= 1'b1;
          end
        end
        default: begin
          if (wr_edge || rd_edge) err_q <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (state_q == RBUSY) rdata_q <= rd_value;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            // Raise the range error so it is visible during the last busy cycle
            if (cnt_q == CNT_W'(2) && cur_oor) err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_dprio_busy = busy_q;
  assign o_dprio_in   = rdata_q;
  assign o_proto_err  = err_q;

endmodule

// File: tb/tb_alt_dfe_dprio_resp.sv
// tb/tb_alt_dfe_dprio_resp.sv - directed self-checking bench for alt_dfe_dprio_resp
module tb_alt_dfe_dprio_resp;

  logic        clk;
  logic        rst_n;
  logic        wren;
  logic        rden;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic [15:0] rdata;
  logic        perr;

  int checks;
  int errors;

  alt_dfe_dprio_resp dut (
    .i_avmm_clk   (clk),
    .i_resetn     (rst_n),
    .i_dprio_wren (wren),
    .i_dprio_rden (rden),
    .i_dprio_addr (addr),
    .i_dprio_data (wdata),
    .o_dprio_busy (busy),
    .o_dprio_in   (rdata),
    .o_proto_err  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one access, hold the strobe for hold cycles, and record what the DUT did
  task automatic run_access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                            input int hold, output int nbusy, output int nerr,
                            output logic [15:0] rd_fall, output logic [15:0] rd_last,
                            output bit err_last);
    logic        prev_busy;
    logic        prev_err;
    logic [15:0] prev_in;
    nbusy = 0; nerr = 0; rd_fall = 16'hxxxx; rd_last = 16'hxxxx; err_last = 1'b0;
    prev_busy = 1'b0; prev_err = 1'b0; prev_in = rdata;
    addr = a; wdata = d;
    if (is_wr) wren = 1'b1; else rden = 1'b1;
    for (int i = 0; i < hold + 10; i++) begin
      cyc();
      if (i + 1 >= hold) begin
        wren = 1'b0; rden = 1'b0;
      end
      if (busy) nbusy++;
      if (perr) nerr++;
      if (prev_busy && !busy) begin
        rd_fall = rdata; rd_last = prev_in; err_last = prev_err;
      end
      prev_busy = busy; prev_err = perr; prev_in = rdata;
    end
  endtask

  task automatic test_reset();
    int nb, ne;
    rst_n = 1'b0; wren = 1'b1; rden = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    repeat (3) cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", perr); end
    rst_n = 1'b1;
    nb = 0; ne = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (busy) nb++;
      if (perr) ne++;
    end
    wren = 1'b0;
    cyc();
    checks++; if (nb !== 0) begin errors++; $display("FAIL held_at_release_busy got %0d exp 0", nb); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL held_at_release_err got %0d exp 0", ne); end
  endtask

  task automatic test_write_read();
    int nb, ne; logic [15:0] rf, rl; bit el;
    run_access(1'b1, 16'h0003, 16'hA5A5, 1, nb, ne, rf, rl, el);
    checks++; if (nb !== 4) begin errors++; $display("FAIL wr_busy_len got %0d exp 4", nb); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL wr_err got %0d exp 0", ne); end
    run_access(1'b0, 16'h0003, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (nb !== 4) begin errors++; $display("FAIL rd_busy_len got %0d exp 4", nb); end
    checks++; if (rf !== 16'hA5A5) begin errors++; $display("FAIL rd_at_fall got %h exp a5a5", rf); end
    checks++; if (rl !== 16'h0000) begin errors++; $display("FAIL rd_before_fall got %h exp 0000", rl); end
    checks++; if (rdata !== 16'hA5A5) begin errors++; $display("FAIL rd_hold got %h exp a5a5", rdata); end
  endtask

  task automatic test_simultaneous();
    int nb, ne; logic [15:0] rf, rl; bit el;
    addr = 16'h0003; wdata = 16'h0000;
    wren = 1'b1; rden = 1'b1;
    cyc();
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL simul_err_pulse got %b exp 1", perr); end
    wren = 1'b0; rden = 1'b0;
    nb = (busy === 1'b1) ? 1 : 0; ne = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (busy) nb++;
      if (perr) ne++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL simul_busy got %0d exp 0", nb); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL simul_err_width got %0d extra exp 0", ne); end
    run_access(1'b0, 16'h0003, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'hA5A5) begin errors++; $display("FAIL simul_reg_kept got %h exp a5a5", rf); end
  endtask

  task automatic test_rd_during_wbusy();
    int nb, ne; logic [15:0] rf, rl; bit el;
    addr = 16'h0007; wdata = 16'h5A5A; wren = 1'b1;
    nb = 0; ne = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) wren = 1'b0;
      if (i == 1) rden = 1'b1;
      if (i == 8) rden = 1'b0;
      if (busy) nb++;
      if (perr) ne++;
    end
    checks++; if (nb !== 4) begin errors++; $display("FAIL wbusy_rd_busy got %0d exp 4", nb); end
    checks++; if (ne !== 1) begin errors++; $display("FAIL wbusy_rd_err got %0d exp 1", ne); end
    run_access(1'b0, 16'h0007, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'h5A5A) begin errors++; $display("FAIL wbusy_write_done got %h exp 5a5a", rf); end
  endtask

  task automatic test_held_wren();
    int nb, ne; logic [15:0] rf, rl; bit el;
    run_access(1'b1, 16'h0009, 16'h1111, 10, nb, ne, rf, rl, el);
    checks++; if (nb !== 4) begin errors++; $display("FAIL held_busy got %0d exp 4", nb); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL held_err got %0d exp 0", ne); end
    run_access(1'b0, 16'h0009, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'h1111) begin errors++; $display("FAIL held_data got %h exp 1111", rf); end
  endtask

  task automatic test_reset_mid();
    int nb, ne; logic [15:0] rf, rl; bit el;
    addr = 16'h0005; wdata = 16'h1234; wren = 1'b1;
    cyc();
    wren = 1'b0;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b exp 0", busy); end
    cyc();
    rst_n = 1'b1;
    cyc();
    run_access(1'b0, 16'h0005, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'h0000) begin errors++; $display("FAIL mid_reg5 got %h exp 0000", rf); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL mid_rd_busy got %0d exp 4", nb); end
  endtask

  task automatic test_addr_range();
    int nb, ne; logic [15:0] rf, rl; bit el;
    run_access(1'b1, 16'h0013, 16'hBEEF, 1, nb, ne, rf, rl, el);
    checks++; if (nb !== 4) begin errors++; $display("FAIL oor_wr_busy got %0d exp 4", nb); end
`ifdef ALT_DFE_DPRIO_RESP_ADDRCHK_EN
    checks++; if (ne !== 1) begin errors++; $display("FAIL oor_wr_err got %0d exp 1", ne); end
    checks++; if (el !== 1'b1) begin errors++; $display("FAIL oor_wr_err_last got %b exp 1", el); end
    run_access(1'b0, 16'h0003, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'h0000) begin errors++; $display("FAIL oor_entry3 got %h exp 0000", rf); end
    run_access(1'b0, 16'h0013, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'hFFFF) begin errors++; $display("FAIL oor_rd got %h exp ffff", rf); end
    checks++; if (ne !== 1) begin errors++; $display("FAIL oor_rd_err got %0d exp 1", ne); end
`else
    checks++; if (ne !== 0) begin errors++; $display("FAIL alias_wr_err got %0d exp 0", ne); end
    run_access(1'b0, 16'h0003, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'hBEEF) begin errors++; $display("FAIL alias_entry3 got %h exp beef", rf); end
    run_access(1'b0, 16'h0013, 16'h0000, 1, nb, ne, rf, rl, el);
    checks++; if (rf !== 16'hBEEF) begin errors++; $display("FAIL alias_rd got %h exp beef", rf); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_rd_during_wbusy();
    test_held_wren();
    test_reset_mid();
    test_addr_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alt_dfe_dprio_resp.md
ALT_DFE_DPRIO_RESP -- requirements
Module: alt_dfe_dprio_resp

Interface
REQ-001 SHALL provide parameter DPRIO_ADDR_WIDTH, default 16, width of the DPRIO address bus.
REQ-002 SHALL provide parameter DPRIO_DATA_WIDTH, default 16, width of the DPRIO data buses.
REQ-003 SHALL provide parameter REG_INDEX_WIDTH, default 4, register-file index width (2**REG_INDEX_WIDTH entries).
REQ-004 SHALL provide parameter BUSY_CYCLES, default 4, busy duration per access, legal range 1..255.
REQ-005 SHALL use one clock, i_avmm_clk; reset is asynchronous and active-low, i_resetn.
REQ-006 i_avmm_clk  input  1  block clock.
REQ-007 i_resetn  input  1  asynchronous active-low reset.
REQ-008 i_dprio_wren  input  1  write strobe from the DPRIO initiator.
REQ-009 i_dprio_rden  input  1  read strobe from the DPRIO initiator.
REQ-010 i_dprio_addr  input  DPRIO_ADDR_WIDTH  access address.
REQ-011 i_dprio_data  input  DPRIO_DATA_WIDTH  write data.
REQ-012 o_dprio_busy  output  1  access in progress.
REQ-013 o_dprio_in  output  DPRIO_DATA_WIDTH  read data returned to the initiator.
REQ-014 o_proto_err  output  1  one-cycle pulse on protocol violation.

Function
REQ-015 SHALL detect requests on the rising edge of each strobe only: strobe high this cycle, low the previous cycle.
REQ-016 SHALL implement FSM states IDLE, WBUSY, RBUSY.
- IDLE -> WBUSY on a wren edge.
- IDLE -> RBUSY on a rden edge.
- WBUSY/RBUSY -> IDLE when the busy counter expires.
REQ-017 SHALL latch address and write data in the cycle a request is accepted.
REQ-018 SHALL drive o_dprio_busy high for exactly BUSY_CYCLES cycles, starting the cycle after acceptance.
REQ-019 SHALL update the write target entry on the last busy cycle, so the new value is visible from the first non-busy cycle.
REQ-020 SHALL load o_dprio_in with the addressed entry on the last RBUSY cycle and hold it until the next read completes.
REQ-021 SHALL index the register file with i_dprio_addr[REG_INDEX_WIDTH-1:0].
REQ-022 A simultaneous wren and rden edge in IDLE SHALL perform no access and pulse o_proto_err; FSM stays in IDLE.
REQ-023 A strobe edge while busy SHALL be ignored and pulse o_proto_err the following cycle.
REQ-024 SHALL not retrigger on a strobe held high across the end of busy.
REQ-025 The busy counter SHALL be ceil(log2(BUSY_CYCLES+1)) bits, load BUSY_CYCLES on acceptance, and decrement to 0 without wrap.

Reset
REQ-026 Asserting i_resetn low SHALL, asynchronously and mid-operation included:
- force IDLE;
- clear o_dprio_busy, o_dprio_in, o_proto_err, the counter and the strobe history;
- clear all register-file entries to 0.
REQ-027 An access interrupted by reset SHALL leave the register file at its reset value.
REQ-028 A strobe already high at reset release SHALL not count as an edge.

Configuration
REQ-029 Macro ALT_DFE_DPRIO_RESP_ADDRCHK_EN SHALL compile in address range checking.
- Defined: a request with any address bit at or above REG_INDEX_WIDTH still runs full busy timing but writes nothing; reads return all-ones (16'hFFFF at default width); o_proto_err pulses on the last busy cycle.
- Undefined: upper address bits are ignored and addresses alias.

Structure
REQ-030 A shared package alt_dfe_dprio_pkg SHALL hold the FSM state typedef, default width constants and the all-ones error-read constant.
REQ-031 The register file SHALL be a sub-module alt_dfe_dprio_regfile with synchronous write, combinational read and asynchronous clear.

Verification (defaults, BUSY_CYCLES=4)
REQ-032 Bench SHALL cover: write addr 16'h0003 data 16'hA5A5, then read addr 3 -> busy high 4 cycles for each access; o_dprio_in=16'hA5A5 on the cycle busy falls.
REQ-033 Bench SHALL cover: wren and rden edges in the same cycle -> o_proto_err single pulse, busy stays 0, registers unchanged.
REQ-034 Bench SHALL cover: rden edge during WBUSY -> ignored, o_proto_err pulse, write completes normally.
REQ-035 Bench SHALL cover: wren held high 10 cycles -> exactly one write, busy high exactly 4 cycles.
REQ-036 Bench SHALL cover: reset asserted on busy cycle 2 of a write of 16'h1234 to addr 5 -> busy 0 immediately; a later read of addr 5 returns 16'h0000.
REQ-037 Bench SHALL cover, with ALT_DFE_DPRIO_RESP_ADDRCHK_EN: write addr 16'h0013 -> entry 3 unchanged, o_proto_err pulse; read addr 16'h0013 -> 16'hFFFF. Without the macro: the write lands in entry 3.
